// File: rtl/hex_rotate_decoder.sv
// hex_rotate_decoder
// Reads back the four active-low 7-segment buses driven by the rotating
// "0 1 E d" display logic, recovers the 2-bit rotation select, and reports it
// only after the same legal frame has been seen STABLE_CYCLES times in a row.
// Frames that are not a legal rotation drive the FAULT state and ERR.
// Optional build macro: HEXDEC_STICKY_ERR_EN -- ERR latches on any FAULT entry
// and holds until RESET. The state machine itself is unaffected.

module hex_rotate_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             CLOCK_50,
   input  logic             RESET,
   input  logic [6:0]       HEX0,
   input  logic [6:0]       HEX1,
   input  logic [6:0]       HEX2,
   input  logic [6:0]       HEX3,
   output logic [1:0]       SEL,
   output logic             SEL_VALID,
   output logic             SEL_CHANGE,
   output logic             ERR,
   output logic [CNT_W-1:0] CHANGE_CNT
);

   localparam int               RUN_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   // Active-low glyphs, bit 0 = segment a.
   localparam logic [6:0] GLYPH_0 = 7'b1000000;
   localparam logic [6:0] GLYPH_1 = 7'b1111001;
   localparam logic [6:0] GLYPH_E = 7'b0000110;
   localparam logic [6:0] GLYPH_D = 7'b0100001;

   typedef enum logic [1:0] {
      ACQUIRE,
      SETTLE,
      LOCKED,
      FAULT
   } state_t;

   // Glyph shown at position p of the base sequence d,E,1,0. Select s puts
   // sequence entry (i+s) mod 4 on HEXi, so HEX0 alone names the select.
   function automatic logic [6:0] glyph_at(input logic [1:0] pos);
      case (pos)
         2'd0:    glyph_at = GLYPH_D;
         2'd1:    glyph_at = GLYPH_E;
         2'd2:    glyph_at = GLYPH_1;
         2'd3:    glyph_at = GLYPH_0;
      endcase
   endfunction

   logic [6:0]       hex0_r, hex1_r, hex2_r, hex3_r;
   logic             hex_vld;
   logic [1:0]       cand;
   logic             glyph_known;
   logic             frame_ok;
   logic             frame_bad;

   state_t           state, state_next;
   logic [1:0]       held, held_next;
   logic [RUN_W-1:0] run, run_next;
   logic             locked_once;
   logic             lock_now;

   logic [1:0]       sel_next;
   logic             valid_next;
   logic             change_next;
   logic             err_next;
   logic [CNT_W-1:0] cnt_next;

   // Input stage: one register on every bus; hex_vld marks that a real frame
   // has been captured since reset so the cleared register is never judged.
   always_ff @(posedge CLOCK_50) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values; combinational blocks use blocking ones.
      if (RESET) begin
         hex0_r  <= '0;
         hex1_r  <= '0;
         hex2_r  <= '0;
         hex3_r  <= '0;
         hex_vld <= 1'b0;
      end else begin
         hex0_r  <= HEX0;
         hex1_r  <= HEX1;
         hex2_r  <= HEX2;
         hex3_r  <= HEX3;
         hex_vld <= 1'b1;
      end
   end

   // Decode the registered frame into a candidate select and a legality flag.
   always_comb begin
      // NOTE: every variable gets a default before any branch, otherwise an
      // uncovered path would hold its old value and infer a latch.
      cand        = 2'd0;
      glyph_known = 1'b1;
      case (hex0_r)
         GLYPH_D: cand = 2'd0;
         GLYPH_E: cand = 2'd1;
         GLYPH_1: cand = 2'd2;
         GLYPH_0: cand = 2'd3;
         default: glyph_known = 1'b0;
      endcase
      frame_ok  = hex_vld && glyph_known
                  && (hex1_r == glyph_at(cand + 2'd1))
                  && (hex2_r == glyph_at(cand + 2'd2))
                  && (hex3_r == glyph_at(cand + 2'd3));
      frame_bad = hex_vld && !frame_ok;
   end

   // Next-state logic plus the next value of every registered output.
   always_comb begin
      state_next = state;
      held_next  = held;
      run_next   = run;

      case (state)
         ACQUIRE, FAULT: begin
            if (frame_ok) begin
               held_next  = cand;
               run_next   = RUN_ONE;
               state_next = SETTLE;
            end else if (frame_bad) begin
               state_next = FAULT;
            end
         end
         SETTLE: begin
            if (frame_ok) begin
               if (cand == held) begin
                  run_next = run + RUN_ONE;
               end else begin
                  held_next = cand;
                  run_next  = RUN_ONE;
               end
            end else if (frame_bad) begin
               state_next = FAULT;
            end
         end
         LOCKED: begin
            if (frame_ok && (cand != SEL)) begin
               held_next  = cand;
               run_next   = RUN_ONE;
               state_next = SETTLE;
            end else if (frame_bad) begin
               state_next = FAULT;
            end
         end
      endcase

      // A run that reaches the target locks on the same edge, which also
      // covers STABLE_CYCLES == 1 where the entry value already qualifies.
      lock_now = (state_next == SETTLE) && (run_next == RUN_TARGET);
      if (lock_now) begin
         state_next = LOCKED;
      end

      sel_next    = SEL;
      valid_next  = (state_next == LOCKED);
      change_next = 1'b0;
      cnt_next    = CHANGE_CNT;
      if (lock_now) begin
         sel_next = held_next;
         if ((held_next != SEL) || !locked_once) begin
            change_next = 1'b1;
            if (CHANGE_CNT != CNT_MAX) begin
               cnt_next = CHANGE_CNT + CNT_W'(1);
            end
         end
      end

`ifdef HEXDEC_STICKY_ERR_EN
      err_next = ERR || (state_next == FAULT);
`else
      err_next = (state_next == FAULT);
`endif
   end

   // State, run tracking and output registers.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state       <= ACQUIRE;
         held        <= 2'd0;
         run         <= '0;
         locked_once <= 1'b0;
         SEL         <= 2'd0;
         SEL_VALID   <= 1'b0;
         SEL_CHANGE  <= 1'b0;
         ERR         <= 1'b0;
         CHANGE_CNT  <= '0;
      end else begin
         state       <= state_next;
         held        <= held_next;
         run         <= run_next;
         locked_once <= locked_once || lock_now;
         SEL         <= sel_next;
         SEL_VALID   <= valid_next;
         SEL_CHANGE  <= change_next;
         ERR         <= err_next;
         CHANGE_CNT  <= cnt_next;
      end
   end

endmodule

// File: tb/tb_hex_rotate_decoder.sv
// Self-checking bench for hex_rotate_decoder (STABLE_CYCLES=4, CNT_W=8).
// A behavioural model tracks run lengths of identical legal frames and the
// resulting lock/err/counter outputs; directed steps add fixed expectations.

module tb_hex_rotate_decoder;

   localparam int STABLE = 4;
   localparam int CNT_W  = 8;
   localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef HEXDEC_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] GD = 7'b0100001;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       h0, h1, h2, h3;
   logic [1:0]       sel;
   logic             sel_valid, sel_change, err;
   logic [CNT_W-1:0] change_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic        p_vld;
   logic [27:0] p_frame;
   int          run;
   int          run_sel;
   int          m_sel;
   bit          m_valid, m_change, m_err, m_first;
   int          m_cnt;

   hex_rotate_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
      .CLOCK_50  (clk),
      .RESET     (rst),
      .HEX0      (h0),
      .HEX1      (h1),
      .HEX2      (h2),
      .HEX3      (h3),
      .SEL       (sel),
      .SEL_VALID (sel_valid),
      .SEL_CHANGE(sel_change),
      .ERR       (err),
      .CHANGE_CNT(change_cnt)
   );

   always #10 clk = ~clk;

   // Legal frame for select s, packed {HEX3,HEX2,HEX1,HEX0}.
   function automatic logic [27:0] frame_of(input int s);
      logic [6:0] seq [4];
      seq = '{GD, GE, G1, G0};
      return {seq[(s + 3) % 4], seq[(s + 2) % 4], seq[(s + 1) % 4], seq[s % 4]};
   endfunction

   function automatic int legal_sel(input logic [27:0] f);
      for (int s = 0; s < 4; s++) begin
         if (f == frame_of(s)) return s;
      end
      return -1;
   endfunction

   task automatic model_edge();
      int c;
      if (rst) begin
         p_vld = 1'b0; p_frame = '0; run = 0; run_sel = 0;
         m_sel = 0; m_valid = 0; m_change = 0; m_err = 0; m_cnt = 0; m_first = 1;
      end else begin
         if (p_vld) begin
            m_change = 0;
            c = legal_sel(p_frame);
            if (c < 0) begin
               run = 0;
               m_valid = 0;
               m_err = 1;
            end else begin
               if (!STICKY) m_err = 0;
               if (!(m_valid && c == m_sel)) begin
                  if (run != 0 && c == run_sel) run++;
                  else begin run = 1; run_sel = c; end
                  m_valid = 0;
                  if (run == STABLE) begin
                     m_valid = 1;
                     if (m_first || c != m_sel) begin
                        m_change = 1;
                        if (m_cnt < CMAX) m_cnt++;
                     end
                     m_first = 0;
                     m_sel = c;
                  end
               end
            end
         end
         p_frame = {h3, h2, h1, h0};
         p_vld   = 1'b1;
      end
   endtask

   // Drive a frame, let one edge pass, advance the model, then settle.
   task automatic tick(input logic [27:0] f);
      {h3, h2, h1, h0} = f;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check(input string tag);
      check_eq({tag, ".sel"},    32'(sel),        32'(m_sel));
      check_eq({tag, ".valid"},  32'(sel_valid),  32'(m_valid));
      check_eq({tag, ".change"}, 32'(sel_change), 32'(m_change));
      check_eq({tag, ".err"},    32'(err),        32'(m_err));
      check_eq({tag, ".cnt"},    32'(change_cnt), 32'(m_cnt));
   endtask

   initial begin
      int pulses;
      int hold;
      logic [27:0] f;

      rst = 1'b1;
      {h3, h2, h1, h0} = '0;

      // Reset with arbitrary buses.
      tick(28'($urandom));
      tick(28'($urandom));
      check("reset");
      check_eq("reset_valid", 32'(sel_valid), 0);
      check_eq("reset_cnt", 32'(change_cnt), 0);

      // First lock on s=2: valid exactly on the fifth edge counting the sample.
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(frame_of(2));
         check("first_wait");
      end
      tick(frame_of(2));
      check("first_lock");
      check_eq("first_valid", 32'(sel_valid), 1);
      check_eq("first_sel", 32'(sel), 2);
      check_eq("first_pulse", 32'(sel_change), 1);
      check_eq("first_cnt", 32'(change_cnt), 1);
      tick(frame_of(2));
      check_eq("first_pulse_once", 32'(sel_change), 0);

      // Rotation sweep from a fresh reset.
      rst = 1'b1;
      tick(frame_of(0));
      tick(frame_of(0));
      rst = 1'b0;
      pulses = 0;
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < 10; i++) begin
            tick(frame_of(s));
            check("sweep");
            pulses += int'(sel_change);
         end
         check_eq("sweep_sel", 32'(sel), 32'(s));
      end
      check_eq("sweep_pulses", 32'(pulses), 4);
      check_eq("sweep_cnt", 32'(change_cnt), 4);

      // Three-cycle holds never lock.
      for (int i = 0; i < 6; i++) begin
         tick(frame_of(i / 3));
         check("short_hold");
      end
      tick(frame_of(1));
      check_eq("short_valid", 32'(sel_valid), 0);
      check_eq("short_sel", 32'(sel), 3);
      check_eq("short_cnt", 32'(change_cnt), 4);

      // Illegal frame while locked at s=1.
      for (int i = 0; i < 10; i++) begin
         tick(frame_of(1));
         check("pre_glitch");
      end
      check_eq("pre_glitch_valid", 32'(sel_valid), 1);
      f = frame_of(1);
      f[20:14] = 7'b1111111;
      tick(f);
      check("glitch_sampled");
      tick(frame_of(1));
      check("glitch_eval");
      check_eq("glitch_err", 32'(err), 1);
      check_eq("glitch_valid", 32'(sel_valid), 0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         tick(frame_of(1));
         check("relock_wait");
         check_eq("relock_wait_valid", 32'(sel_valid), 0);
         pulses += int'(sel_change);
      end
      check_eq("glitch_err_after", 32'(err), STICKY ? 1 : 0);
      tick(frame_of(1));
      check("relock");
      check_eq("relock_valid", 32'(sel_valid), 1);
      check_eq("relock_sel", 32'(sel), 1);
      pulses += int'(sel_change);
      check_eq("relock_no_pulse", 32'(pulses), 0);

      // Flicker between s=0 and s=3 never locks.
      for (int i = 0; i < 20; i++) begin
         tick(frame_of((i % 2) * 3));
         check("flicker");
      end
      check_eq("flicker_valid", 32'(sel_valid), 0);
      check_eq("flicker_err", 32'(err), STICKY ? 1 : 0);

      // Reset in the middle of SETTLE; relock then takes the full latency.
      for (int i = 0; i < 10; i++) tick(frame_of(2));
      tick(frame_of(0));
      tick(frame_of(0));
      tick(frame_of(0));
      rst = 1'b1;
      tick(frame_of(0));
      check("mid_reset");
      check_eq("mid_reset_sel", 32'(sel), 0);
      check_eq("mid_reset_cnt", 32'(change_cnt), 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(frame_of(3));
         check("post_reset_wait");
      end
      tick(frame_of(3));
      check_eq("post_reset_lock", 32'(sel_valid), 1);

      // Saturation: 255 changes, then one more.
      rst = 1'b1;
      tick(frame_of(0));
      rst = 1'b0;
      for (int i = 0; i < CMAX; i++) begin
         for (int k = 0; k < 6; k++) begin
            tick(frame_of(i % 2));
            check("preload");
         end
      end
      check_eq("preload_cnt", 32'(change_cnt), CMAX);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         tick(frame_of(CMAX % 2));
         check("saturate");
         pulses += int'(sel_change);
      end
      check_eq("saturate_pulse", 32'(pulses), 1);
      check_eq("saturate_cnt", 32'(change_cnt), CMAX);

      // Randomised mix of legal holds and corrupt frames.
      rst = 1'b1;
      tick(frame_of(0));
      rst = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            f = frame_of(int'($urandom_range(0, 3)));
            f[$urandom_range(0, 27)] ^= 1'b1;
            hold = int'($urandom_range(1, 2));
         end else begin
            f = frame_of(int'($urandom_range(0, 3)));
            hold = int'($urandom_range(1, 8));
         end
         for (int k = 0; k < hold; k++) begin
            tick(f);
            check("random");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
